uart_rx_deserializer: RTL and testbench
=======================================

// Module: uart_rx_deserializer
// PURPOSE
//  Receive half of the UART core: 8N1 serial-to-parallel converter upstream of the 8x8 RX FIFO.
//  Oversamples rxd at 16x, majority-votes each bit, checks start/stop framing, pushes good bytes.
//  Drives the FIFO write port (data_in/wr_en) and reads its full flag.
//  Reports framing and overrun errors as single-cycle pulses to the status logic.
// PARAMETERS
//  CLK_DIV     27   clock cycles per oversample tick (clock / (baud*16)); legal range >= 2
//  OVERSAMPLE  16   ticks per bit; fixed, not to be overridden
// PORTS
//  clock        in   1  system clock, all logic on posedge
//  reset        in   1  synchronous, active-high
//  rxd          in   1  asynchronous serial line, idle high
//  fifo_full    in   1  RX FIFO full flag
//  rx_data      out  8  received byte, valid only while rx_wr_en=1 (drives FIFO data_in)
//  rx_wr_en     out  1  one-cycle FIFO write strobe
//  frame_err    out  1  one-cycle pulse: stop bit sampled 0, byte discarded
//  overrun_err  out  1  one-cycle pulse: good byte arrived while fifo_full=1, byte dropped
//  rx_busy      out  1  high from start-bit detection until return to IDLE
// BEHAVIOUR
//  Reset: rx_data=0, rx_wr_en=0, frame_err=0, overrun_err=0, rx_busy=0; state IDLE; tick counter 0,
//   tick_cnt 0, bit_idx 0; both synchroniser flops = 1 (line treated idle).
//  Sync: rxd through 2 flops -> rxs; all decisions use rxs only (2-cycle input latency).
//  Tick gen: div counter 0..CLK_DIV-1, free-running; tick=1 for one cycle when counter==CLK_DIV-1.
//  tick_cnt (4 bits) counts ticks within a bit, 0..15, wraps to 0; cleared on entering START.
//  Vote: rxs captured at tick_cnt 7,8,9; bit value = majority of the three, resolved on tick 9.
//  States:
//   IDLE      rxs==0 on any cycle -> START, tick_cnt=0, rx_busy=1.
//   START     at vote (tick 9): 0 -> DATA, bit_idx=0; 1 -> IDLE (glitch rejected, no outputs).
//   DATA      at each vote shift bit into shreg LSB-first; after bit_idx==7 -> STOP.
//   STOP      at vote: 1 and !fifo_full -> rx_data=shreg, rx_wr_en=1, -> IDLE;
//             1 and fifo_full -> overrun_err=1, rx_data unchanged, -> IDLE;
//             0 -> frame_err=1 -> WAIT_HI.
//   WAIT_HI   stay until rxs==1 (break/long-low line never re-triggers a start) -> IDLE.
//  Output timing: rx_wr_en / frame_err / overrun_err rise on the edge where the stop vote resolves,
//   and clear on the next edge (exactly one cycle). At most one of the three high in any cycle.
//  rx_data holds the last pushed byte between writes (FIFO samples it only with rx_wr_en).
//  fifo_full sampled only at the stop vote; changes elsewhere are ignored.
//  Back-to-back: IDLE reached at stop tick 9, so next start edge (>=6 ticks later) is caught.
//  Baud error tolerance: vote at mid-bit gives about +/-4% total mismatch.
//  Reset mid-frame: abandons frame, no write, no error pulse; a line still low after reset
//   triggers START normally (start validated by vote).
//  rx_busy = (state != IDLE), registered with the state.
// STRUCTURE
//  Shared package uart_pkg: state enum {IDLE,START,DATA,STOP,WAIT_HI}; OVERSAMPLE=16;
//   VOTE_T0/T1/T2 = 7/8/9; DATA_BITS=8 (the TX side uses the same constants).
//  Sub-module uart_baud_tick (CLK_DIV counter -> tick); also used by the TX serializer.
//  Remainder is one FSM process plus the datapath registers (shreg, bit_idx, tick_cnt, vote regs).
// TESTING  (CLK_DIV=4 -> 64 clocks/bit; bit values driven on rxd for whole bit periods)
//  1 Frame 0xA5, stop=1, fifo_full=0 -> exactly one rx_wr_en pulse with rx_data=0xA5; no error pulses.
//  2 rxd low for 20 clocks in IDLE -> no rx_wr_en, no error pulses; rx_busy pulses then returns to 0.
//  3 Frame 0x3C with stop=0, then line held low for 10 bits -> one frame_err pulse; no write; no restart
//     until rxd high; a following 0x81 frame -> one write of 0x81.
//  4 fifo_full=1 during frame 0x55 -> one overrun_err pulse; rx_wr_en stays 0; rx_data unchanged.
//  5 Back-to-back frames 0x00, 0xFF, 0x01 with no idle gap -> three writes in order, 640 clocks apart.
//  6 Reset asserted mid-DATA of 0xC3 -> all outputs 0, rx_busy=0; the next full frame 0x7E -> one write of 0x7E.

Source files
------------

// File: rtl/uart_pkg.sv
// Constants and types shared by the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } uart_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned VOTE_T0    = 7;
    localparam int unsigned VOTE_T1    = 8;
    localparam int unsigned VOTE_T2    = 9;
    localparam int unsigned DATA_BITS  = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle oversample tick every CLK_DIV clocks.
module uart_baud_tick #(
    parameter int unsigned CLK_DIV = 27
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            div_cnt <= '0;
        else if (div_cnt == LAST)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + CNT_W'(1);
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, framing/overrun detection,
// write port into the RX FIFO.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 27
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    input  logic       fifo_full,
    output logic [7:0] rx_data,
    output logic       rx_wr_en,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    uart_state_t state;
    logic        sync1;
    logic        rxs;
    logic        tick;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        vote0;
    logic        vote1;
    logic        vote_now;
    logic        vote_bit;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // Reset to 1 so the line reads idle until the synchroniser fills.
    always_ff @(posedge clock) begin
        if (reset)
            {sync1, rxs} <= 2'b11;
        else
            {sync1, rxs} <= {rxd, sync1};
    end

    assign vote_now = tick && (tick_cnt == 4'(VOTE_T2));
    assign vote_bit = majority3(vote0, vote1, rxs);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            vote0       <= 1'b1;
            vote1       <= 1'b1;
            rx_data     <= '0;
            rx_wr_en    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            rx_wr_en    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;

            if (tick) begin
                tick_cnt <= tick_cnt + 4'd1;
                if (tick_cnt == 4'(VOTE_T0)) vote0 <= rxs;
                if (tick_cnt == 4'(VOTE_T1)) vote1 <= rxs;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        tick_cnt <= '0;
                        rx_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (vote_now) begin
                        if (!vote_bit) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (vote_now) begin
                        shreg <= {vote_bit, shreg[7:1]};
                        if (bit_idx == 3'(DATA_BITS - 1))
                            state <= STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (vote_now) begin
                        if (vote_bit) begin
                            if (!fifo_full) begin
                                rx_data  <= shreg;
                                rx_wr_en <= 1'b1;
                            end else begin
                                overrun_err <= 1'b1;
                            end
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HI;
                        end
                    end
                end
                WAIT_HI: begin
                    if (rxs) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: directed scenarios plus random frames against a frame-level outcome model.
module tb_uart_rx_deserializer;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned BIT_CLKS = CLK_DIV * 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       fifo_full = 1'b0;
    logic [7:0] rx_data;
    logic       rx_wr_en;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    uart_rx_deserializer #(.CLK_DIV(CLK_DIV)) dut (
        .clock       (clock),
        .reset       (reset),
        .rxd         (rxd),
        .fifo_full   (fifo_full),
        .rx_data     (rx_data),
        .rx_wr_en    (rx_wr_en),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed activity
    int         cyc = 0;
    logic [7:0] got_q[$];
    int         wr_cyc_q[$];
    int         fe_cnt = 0;
    int         oe_cnt = 0;
    bit         saw_busy = 0;
    logic       prev_pulse = 1'b0;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        if (reset) begin
            prev_pulse = 1'b0;
        end else begin
            if (rx_wr_en) begin
                got_q.push_back(rx_data);
                wr_cyc_q.push_back(cyc);
            end
            if (frame_err)   fe_cnt++;
            if (overrun_err) oe_cnt++;
            if (rx_busy)     saw_busy = 1;
            if (rx_wr_en || frame_err || overrun_err) begin
                check_eq("one_hot", int'(rx_wr_en) + int'(frame_err) + int'(overrun_err), 1);
                check_eq("pulse_width", prev_pulse, 0);
            end
            prev_pulse = rx_wr_en | frame_err | overrun_err;
        end
    end

    // Reference model: outcome of each frame from its stop bit and the FIFO flag
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    int         exp_oe = 0;
    logic [7:0] last_data = 8'h00;

    task automatic expect_frame(input logic [7:0] d, input bit stop, input bit full);
        if (!stop)
            exp_fe++;
        else if (full)
            exp_oe++;
        else begin
            exp_q.push_back(d);
            last_data = d;
        end
    endtask

    task automatic clear_obs();
        got_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
        fe_cnt = 0;
        oe_cnt = 0;
        exp_fe = 0;
        exp_oe = 0;
    endtask

    task automatic verify(input string tag);
        check_eq({tag, "_nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_data"}, got_q[i], exp_q[i]);
        check_eq({tag, "_frame_err"}, fe_cnt, exp_fe);
        check_eq({tag, "_overrun"}, oe_cnt, exp_oe);
        check_eq({tag, "_rx_data_hold"}, rx_data, last_data);
        clear_obs();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        wait_clks(n * BIT_CLKS);
    endtask

    initial begin
        logic [7:0] d;
        bit         full;

        wait_clks(4);
        check_eq("rst_rx_data", rx_data, 8'h00);
        check_eq("rst_wr_en", rx_wr_en, 0);
        check_eq("rst_frame_err", frame_err, 0);
        check_eq("rst_overrun", overrun_err, 0);
        check_eq("rst_busy", rx_busy, 0);
        reset = 1'b0;
        idle_bits(2);

        // Clean frame
        saw_busy = 0;
        send_frame(8'hA5, 1'b1);
        expect_frame(8'hA5, 1'b1, 1'b0);
        idle_bits(1);
        check_eq("t1_busy_seen", saw_busy, 1);
        check_eq("t1_busy_idle", rx_busy, 0);
        verify("t1");

        // Short low glitch is rejected by the start vote
        saw_busy = 0;
        rxd = 1'b0;
        wait_clks(20);
        idle_bits(2);
        check_eq("t2_busy_seen", saw_busy, 1);
        check_eq("t2_busy_idle", rx_busy, 0);
        verify("t2");

        // Framing error followed by a long break, then a good frame
        send_frame(8'h3C, 1'b0);
        expect_frame(8'h3C, 1'b0, 1'b0);
        rxd = 1'b0;
        wait_clks(10 * BIT_CLKS);
        check_eq("t3_fe_during_break", fe_cnt, 1);
        check_eq("t3_busy_in_break", rx_busy, 1);
        idle_bits(1);
        send_frame(8'h81, 1'b1);
        expect_frame(8'h81, 1'b1, 1'b0);
        idle_bits(1);
        verify("t3");

        // Overrun while FIFO is full
        fifo_full = 1'b1;
        send_frame(8'h55, 1'b1);
        expect_frame(8'h55, 1'b1, 1'b1);
        fifo_full = 1'b0;
        idle_bits(1);
        verify("t4");

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h01, 1'b1);
        expect_frame(8'h00, 1'b1, 1'b0);
        expect_frame(8'hFF, 1'b1, 1'b0);
        expect_frame(8'h01, 1'b1, 1'b0);
        idle_bits(1);
        if (wr_cyc_q.size() == 3) begin
            check_eq("t5_gap1", wr_cyc_q[1] - wr_cyc_q[0], 10 * BIT_CLKS);
            check_eq("t5_gap2", wr_cyc_q[2] - wr_cyc_q[1], 10 * BIT_CLKS);
        end
        verify("t5");

        // Reset in the middle of the data bits abandons the frame
        d = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        reset = 1'b1;
        rxd = 1'b1;
        wait_clks(3);
        check_eq("t6_rst_wr_en", rx_wr_en, 0);
        check_eq("t6_rst_frame_err", frame_err, 0);
        check_eq("t6_rst_overrun", overrun_err, 0);
        check_eq("t6_rst_busy", rx_busy, 0);
        check_eq("t6_rst_rx_data", rx_data, 8'h00);
        reset = 1'b0;
        last_data = 8'h00;
        clear_obs();
        idle_bits(1);
        send_frame(8'h7E, 1'b1);
        expect_frame(8'h7E, 1'b1, 1'b0);
        idle_bits(1);
        verify("t6");

        // Random frames with random gaps and FIFO-full state
        for (int n = 0; n < 12; n++) begin
            d    = 8'($urandom_range(0, 255));
            full = ($urandom_range(0, 3) == 0);
            rxd  = 1'b1;
            wait_clks($urandom_range(0, 63));
            fifo_full = full;
            send_frame(d, 1'b1);
            expect_frame(d, 1'b1, full);
            fifo_full = 1'b0;
            idle_bits(1);
            verify("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
